// File: rtl/ov7670_cap_pkg.sv
// ----------------------------------------------------------------------------
// ov7670_cap_pkg
// Shared constants for the OV7670 capture stage:
//   - FSM state encoding (IDLE / WAIT_FRAME / CAPTURE)
//   - default active window (640 words x 480 lines)
//   - default X/Y counter widths
// ----------------------------------------------------------------------------
package ov7670_cap_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned X_W_DEF      = 11;
  localparam int unsigned Y_W_DEF      = 10;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_CAPTURE    = 2'd2;

endpackage

// File: rtl/ov7670_capture_sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
// One-cycle history register on a signal already synchronous to clk_i, with
// rise/fall pulses derived from the registered history and the current sample.
// A pulse is high during the cycle whose closing edge first samples the new
// level, so logic clocked on that edge reacts to the transition.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset (clears history)
//   sig_i   monitored level
//   rise_o  sig_i high now, low on the previous edge
//   fall_o  sig_i low now, high on the previous edge
// ----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic hist_q;

  // NOTE: reset is synchronous: it is sampled inside the clocked block like any other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= 1'b0;
    else       hist_q <= sig_i;
  end

  assign rise_o = sig_i & ~hist_q;
  assign fall_o = ~sig_i & hist_q;

endmodule

// File: rtl/ov7670_capture.sv
// ----------------------------------------------------------------------------
// ov7670_capture
// Pixel-clock-domain capture stage: pairs the sensor's YUV 4:2:2 byte stream
// (Cb Y Cr Y) into 16-bit {luma, chroma} words, tracks word/line position,
// counts completed frames and arms/disarms capture on frame boundaries only.
// Ports:
//   iCLK         pixel clock (only clock)
//   iRST         synchronous active-high reset
//   iDATA        sensor byte (registered upstream)
//   iVSYNC       high during vertical blanking
//   iHREF        line valid
//   iSTART/iEND  level arm/disarm requests (iEND wins)
//   oYCbCr       {luma, chroma} word
//   oDVAL        one-cycle word strobe
//   oX_Cont      word index of oYCbCr
//   oY_Cont      line index of oYCbCr
//   oFrame_Cont  completed-frame count (wraps)
//   oSOF         one-cycle pulse at the start of a captured frame
//   oLINE_ERR    sticky malformed-line flag
// ----------------------------------------------------------------------------
module ov7670_capture
  import ov7670_cap_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic [7:0]     iDATA,
  input  logic           iVSYNC,
  input  logic           iHREF,
  input  logic           iSTART,
  input  logic           iEND,
  output logic [15:0]    oYCbCr,
  output logic           oDVAL,
  output logic [X_W-1:0] oX_Cont,
  output logic [Y_W-1:0] oY_Cont,
  output logic [31:0]    oFrame_Cont,
  output logic           oSOF,
  output logic           oLINE_ERR
);

  localparam logic [X_W-1:0] H_LIM = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_LIM = Y_W'(V_ACTIVE);

  logic vs_rise, vs_fall, href_rise, href_fall;

  sync_edge_det u_vs_det (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .sig_i  (iVSYNC),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  sync_edge_det u_href_det (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .sig_i  (iHREF),
    .rise_o (href_rise),
    .fall_o (href_fall)
  );

  logic [1:0]     state_q, state_d;
  logic           end_pend_q, end_pend_d;
  logic           phase_q, phase_d;
  logic           line_act_q, line_act_d;
  logic [7:0]     chroma_q, chroma_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [31:0]    frame_cnt_q, frame_cnt_d;
  logic [15:0]    ycbcr_q, ycbcr_d;
  logic           dval_q, dval_d;
  logic [X_W-1:0] xo_q, xo_d;
  logic [Y_W-1:0] yo_q, yo_d;
  logic           sof_q, sof_d;
  logic           err_q, err_d;

  logic capturing, byte_ok, phase_eff, line_end;

  always_comb begin
    capturing = (state_q == ST_CAPTURE);
    // HREF during vertical blanking is not picture data.
    byte_ok   = capturing && iHREF && !iVSYNC;
    // The first byte of a line is always chroma, whatever phase was left over.
    phase_eff = href_rise ? 1'b0 : phase_q;
    // A line ends on HREF falling or, mid-line, when VSYNC rises.
    line_end  = capturing && line_act_q && (href_fall || vs_rise);
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned (no latches).
    state_d     = state_q;
    end_pend_d  = end_pend_q;
    phase_d     = phase_q;
    line_act_d  = line_act_q;
    chroma_d    = chroma_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    ycbcr_d     = ycbcr_q;
    dval_d      = 1'b0;
    xo_d        = xo_q;
    yo_d        = yo_q;
    sof_d       = 1'b0;
    err_d       = err_q;

    // Frame-level control: arming and disarming only take effect between frames.
    case (state_q)
      ST_IDLE: begin
        if (iSTART && !iEND) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (iEND) begin
          state_d = ST_IDLE;
        end else if (vs_fall) begin
          state_d = ST_CAPTURE;
          sof_d   = 1'b1;
          yo_d    = '0;
        end
      end
      ST_CAPTURE: begin
        if (iEND) end_pend_d = 1'b1;
        if (vs_rise) begin
          frame_cnt_d = frame_cnt_q + 32'd1;
          state_d     = (end_pend_q || iEND) ? ST_IDLE : ST_WAIT_FRAME;
          end_pend_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (vs_fall) y_d = '0;

    if (href_rise) begin
      phase_d = 1'b0;
      x_d     = '0;
      if (capturing && !iVSYNC) line_act_d = 1'b1;
    end

    if (byte_ok) begin
      if (!phase_eff) begin
        chroma_d = iDATA;
        phase_d  = 1'b1;
      end else begin
        phase_d = 1'b0;
        // Out-of-window words are dropped; X stops at the limit so it never wraps.
        if (x_q < H_LIM && y_q < V_LIM) begin
          ycbcr_d = {iDATA, chroma_q};
          dval_d  = 1'b1;
          xo_d    = x_q;
          yo_d    = y_q;
          x_d     = x_q + X_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (line_end) begin
      line_act_d = 1'b0;
      phase_d    = 1'b0;
      // Odd byte count: the unpaired trailing chroma byte is discarded.
      if (phase_q) err_d = 1'b1;
      if (x_q != '0) begin
        y_d = y_q + Y_W'(1);
        if (x_q < H_LIM) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      end_pend_q  <= 1'b0;
      phase_q     <= 1'b0;
      line_act_q  <= 1'b0;
      chroma_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      ycbcr_q     <= '0;
      dval_q      <= 1'b0;
      xo_q        <= '0;
      yo_q        <= '0;
      sof_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      end_pend_q  <= end_pend_d;
      phase_q     <= phase_d;
      line_act_q  <= line_act_d;
      chroma_q    <= chroma_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      ycbcr_q     <= ycbcr_d;
      dval_q      <= dval_d;
      xo_q        <= xo_d;
      yo_q        <= yo_d;
      sof_q       <= sof_d;
      err_q       <= err_d;
    end
  end

  assign oYCbCr      = ycbcr_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = xo_q;
  assign oY_Cont     = yo_q;
  assign oFrame_Cont = frame_cnt_q;
  assign oSOF        = sof_q;
  assign oLINE_ERR   = err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// ----------------------------------------------------------------------------
// tb_ov7670_capture
// Directed bench for ov7670_capture on a reduced 16x8 window. A driver emits
// lines whose bytes encode position (chroma = 0x10+x, luma = 0x80+y) and queues
// the words it expects; a monitor pops and compares every strobed word.
// ----------------------------------------------------------------------------
module tb_ov7670_capture;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int XW = 11;
  localparam int YW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    data;
  logic          vsync, href, start, stop;
  logic [15:0]   ycbcr;
  logic          dval;
  logic [XW-1:0] x_cont;
  logic [YW-1:0] y_cont;
  logic [31:0]   frame_cnt;
  logic          sof, line_err;

  always #5 clk = ~clk;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW)) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iDATA       (data),
    .iVSYNC      (vsync),
    .iHREF       (href),
    .iSTART      (start),
    .iEND        (stop),
    .oYCbCr      (ycbcr),
    .oDVAL       (dval),
    .oX_Cont     (x_cont),
    .oY_Cont     (y_cont),
    .oFrame_Cont (frame_cnt),
    .oSOF        (sof),
    .oLINE_ERR   (line_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] w;
    int          x;
    int          y;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          words_seen;
  int          sof_seen;
  bit          got_first;
  logic [15:0] first_w;
  int          last_x, last_y;
  logic        prev_dval = 1'b0;

  // Monitor samples 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (dval) begin
      check("dval_gap", prev_dval, 0);
      check("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("word", ycbcr, mon_e.w);
        check("word_x", x_cont, mon_e.x);
        check("word_y", y_cont, mon_e.y);
      end
      words_seen++;
      if (!got_first) begin
        got_first = 1'b1;
        first_w   = ycbcr;
      end
      last_x = int'(x_cont);
      last_y = int'(y_cont);
    end
    if (sof) begin
      sof_seen++;
      check("sof_y", y_cont, 0);
    end
    prev_dval = dval;
  end

  int line_len[V];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int j, input int y, input bit cap);
    href = 1'b1;
    data = (j % 2 == 0) ? 8'(8'h10 + j / 2) : 8'(8'h80 + y);
    if (cap && (j % 2 == 1) && (j / 2 < H) && (y < V))
      sb.push_back('{{8'(8'h80 + y), 8'(8'h10 + j / 2)}, j / 2, y});
    @(negedge clk);
  endtask

  task automatic send_line(input int nbytes, input int y, input bit cap);
    for (int j = 0; j < nbytes; j++) send_byte(j, y, cap);
    href = 1'b0;
    data = 8'h00;
    tick(4);
  endtask

  // start_at / end_at: line index before which iSTART / iEND is pulsed (-1 = none).
  task automatic send_frame(input bit cap, input int start_at, input int end_at);
    vsync = 1'b0;
    tick(3);
    for (int y = 0; y < V; y++) begin
      if (y == start_at) begin start = 1'b1; tick(1); start = 1'b0; end
      if (y == end_at)   begin stop  = 1'b1; tick(1); stop  = 1'b0; end
      send_line(line_len[y], y, cap);
    end
    vsync = 1'b1;
    tick(6);
  endtask

  task automatic check_frame(input string pfx, input int exp_words, input int exp_frames,
                             input int exp_sof);
    check({pfx, "_words"}, words_seen, exp_words);
    check({pfx, "_sb_empty"}, sb.size(), 0);
    check({pfx, "_frames"}, frame_cnt, exp_frames);
    check({pfx, "_sof_count"}, sof_seen, exp_sof);
    words_seen = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    sb.delete();
    words_seen = 0;
    sof_seen   = 0;
  endtask

  task automatic arm();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data = 8'h00; vsync = 1'b1; href = 1'b0; start = 1'b0; stop = 1'b0;
    words_seen = 0; sof_seen = 0; got_first = 1'b0; first_w = '0; last_x = 0; last_y = 0;
    for (int i = 0; i < V; i++) line_len[i] = 2 * H;

    // Reset state.
    tick(3);
    check("rst_ycbcr", ycbcr, 0);
    check("rst_dval", dval, 0);
    check("rst_x", x_cont, 0);
    check("rst_y", y_cont, 0);
    check("rst_frames", frame_cnt, 0);
    check("rst_sof", sof, 0);
    check("rst_err", line_err, 0);
    rst = 1'b0;
    tick(2);

    // Two full frames.
    arm();
    send_frame(1'b1, -1, -1);
    check("f1_first_word", first_w, 16'h8010);
    check("f1_last_x", last_x, H - 1);
    check("f1_last_y", last_y, V - 1);
    check_frame("f1", H * V, 1, 1);
    send_frame(1'b1, -1, -1);
    check_frame("f2", H * V, 2, 2);
    check("f2_err", line_err, 0);

    // iEND at line 3: frame completes, then capture stops.
    send_frame(1'b1, -1, 3);
    check_frame("end_f", H * V, 3, 3);
    send_frame(1'b0, -1, -1);
    check_frame("after_end", 0, 3, 3);

    // iSTART mid-frame: nothing until the following vs_fall.
    send_frame(1'b0, 2, -1);
    check_frame("mid_start", 0, 3, 3);
    send_frame(1'b1, -1, -1);
    check_frame("post_start", H * V, 4, 4);
    check("post_start_err", line_err, 0);

    // Odd byte count: trailing byte dropped, next line normal.
    do_reset();
    check("odd_pre_err", line_err, 0);
    check("odd_pre_frames", frame_cnt, 0);
    arm();
    line_len[0] = 2 * H + 1;
    send_frame(1'b1, -1, -1);
    check_frame("odd", H * V, 1, 1);
    check("odd_err", line_err, 1);

    // Overlong line: words past H suppressed.
    do_reset();
    check("long_pre_err", line_err, 0);
    arm();
    line_len[0] = 2 * H + 20;
    send_frame(1'b1, -1, -1);
    check_frame("long", H * V, 1, 1);
    check("long_err", line_err, 1);

    // Short line: 10 bytes -> 5 words.
    do_reset();
    check("short_pre_err", line_err, 0);
    arm();
    line_len[0] = 10;
    send_frame(1'b1, -1, -1);
    check_frame("short", 5 + H * (V - 1), 1, 1);
    check("short_err", line_err, 1);
    line_len[0] = 2 * H;

    // Reset mid-frame at X=H/2-1, Y=3.
    do_reset();
    arm();
    vsync = 1'b0;
    tick(3);
    for (int y = 0; y < 3; y++) send_line(2 * H, y, 1'b1);
    for (int j = 0; j < H; j++) send_byte(j, 3, 1'b1);
    check("pre_rst_x", x_cont, H / 2 - 1);
    check("pre_rst_y", y_cont, 3);
    check("pre_rst_words", words_seen, 3 * H + H / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ycbcr", ycbcr, 0);
    check("mid_rst_dval", dval, 0);
    check("mid_rst_x", x_cont, 0);
    check("mid_rst_y", y_cont, 0);
    check("mid_rst_frames", frame_cnt, 0);
    check("mid_rst_sof", sof, 0);
    check("mid_rst_err", line_err, 0);
    @(negedge clk);
    rst = 1'b0; href = 1'b0; data = 8'h00;
    sb.delete();
    words_seen = 0;
    sof_seen   = 0;
    tick(4);
    for (int y = 4; y < V; y++) send_line(2 * H, y, 1'b0);
    vsync = 1'b1;
    tick(6);
    check_frame("idle_after_rst", 0, 0, 0);
    send_frame(1'b0, -1, -1);
    check_frame("idle_frame", 0, 0, 0);
    arm();
    tick(10);
    check("armed_no_sof", sof_seen, 0);
    send_frame(1'b1, -1, -1);
    check_frame("rearm", H * V, 1, 1);
    check("rearm_err", line_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side capture stage, clocked by the OV7670 pixel clock, feeding the SDRAM frame-buffer write FIFO. It assembles the sensor's 8-bit YUV 4:2:2 byte stream (Cb Y Cr Y order) into 16-bit words. It also tracks pixel and line position and counts captured frames. Capture is armed and disarmed only on frame boundaries, so every frame written to memory is whole.

## Interface
Parameters:
- H_ACTIVE, 640: 16-bit words per line.
- V_ACTIVE, 480: lines per frame.
- X_W, 11: X counter width.
- Y_W, 10: Y counter width.

Ports:
- iCLK  in  1  pixel clock; the only clock.
- iRST  in  1  reset; synchronous, active-high.
- iDATA  in  8  sensor byte, already registered at the top level.
- iVSYNC  in  1  frame sync; high during vertical blanking.
- iHREF  in  1  line valid.
- iSTART  in  1  level; arm capture.
- iEND  in  1  level; disarm capture.
- oYCbCr  out  16  {luma, chroma}.
- oDVAL  out  1  one-cycle word strobe.
- oX_Cont  out  X_W  word index of the current oYCbCr.
- oY_Cont  out  Y_W  line index of the current oYCbCr.
- oFrame_Cont  out  32  completed-frame count.
- oSOF  out  1  one-cycle pulse at the start of a captured frame.
- oLINE_ERR  out  1  sticky flag: malformed line seen.

## Operation
- Edge detect: iVSYNC and iHREF each have a 1-cycle history register.
  - vs_fall marks frame start; vs_rise marks frame end.
  - href_rise marks line start.
- FSM:
  - IDLE: iSTART moves to WAIT_FRAME.
  - WAIT_FRAME: vs_fall moves to CAPTURE and pulses oSOF. iEND returns to IDLE.
  - CAPTURE: on vs_rise, increment oFrame_Cont. Then go to IDLE if iEND has been latched during the frame, else to WAIT_FRAME.
  - iEND during CAPTURE is latched into end_pend and never cuts a frame short.
  - If iSTART and iEND are both high, iEND wins.
- Byte pairing (CAPTURE, iHREF high only):
  - phase toggles on every byte and clears to 0 on href_rise.
  - phase 0: iDATA goes to chroma holding register.
  - phase 1: output {iDATA, chroma} and assert oDVAL.
- Position:
  - X clears on href_rise and increments after each emitted word.
  - Y clears on vs_fall, and increments on iHREF falling edge if the line emitted at least one word.
  - oX_Cont/oY_Cont show the position of the word currently on oYCbCr.
- Boundaries:
  - Words at X ≥ H_ACTIVE or lines at Y ≥ V_ACTIVE are dropped (oDVAL stays low) and set oLINE_ERR.
  - A line ending on phase 1 (odd byte count) drops its trailing byte and sets oLINE_ERR.
  - A line ending with 0 < X < H_ACTIVE sets oLINE_ERR.
  - iHREF high while iVSYNC is high is ignored; no error.
  - vs_rise mid-line ends the line and the frame at once.
  - oFrame_Cont wraps from 2^32−1 to 0.
  - oLINE_ERR clears only on iRST.
- Reset (any time, including mid-frame):
  - State goes to IDLE; all counters, phase, end_pend and edge history clear.
  - All outputs go to 0.

## Timing
- Latency: oDVAL/oYCbCr/oX_Cont/oY_Cont are registered and valid the cycle after the edge sampling the phase-1 byte.
- Strobe rate: oDVAL is high at most every other cycle and never on consecutive cycles.
- oSOF is registered and asserts the cycle after the vs_fall detection edge; Y is 0 on that cycle.
- oFrame_Cont updates the cycle after vs_rise is detected.
- There is no backpressure: the downstream FIFO must accept every oDVAL.
- iSTART/iEND are sampled each cycle. Synchronizing them into iCLK is the caller's responsibility.

## Structure
- Package ov7670_cap_pkg holds:
  - FSM state encoding (IDLE=0, WAIT_FRAME=1, CAPTURE=2);
  - default H_ACTIVE/V_ACTIVE;
  - counter widths.
- One sub-module, sync_edge_det (registered rise/fall pulses), instantiated for iVSYNC and iHREF.

## Test plan
- Reset, iSTART, 2 frames of 640×480 with byte sequence 0x10,0x80,… → 307200 oDVAL per frame, first word 0x8010, last X=639 Y=479, oFrame_Cont=2, oLINE_ERR=0.
- iSTART asserted mid-frame → no oDVAL until the next vs_fall. oSOF then pulses once, with Y=0.
- iEND asserted at line 100 → frame completes all 480 lines, oFrame_Cont increments, FSM returns to IDLE, next frame emits nothing.
- Line of 1281 bytes → 640 words emitted, trailing byte dropped, oLINE_ERR=1; next line is captured normally.
- Line of 1300 bytes → words 640–649 suppressed and oLINE_ERR=1. A separate 600-byte line gives 300 words and oLINE_ERR=1.
- iRST pulsed at X=320 Y=200 → all outputs 0 the next cycle. After reset the block stays in IDLE until iSTART, then waits for vs_fall.
